z80_bank_bridge: RTL
====================

Z80_BANK_BRIDGE -- requirements
Module: z80_bank_bridge

Interface
REQ-001 The block SHALL have these ports:
- MCLK  in  1  system clock; all state changes on the rising edge.
- SRES  in  1  reset; synchronous, active-high.
- z_req  in  1  one-cycle pulse that starts a Z80 memory cycle; z_addr, z_wr and z_wdata are valid in that cycle.
- z_wr  in  1  1 = write, 0 = read.
- z_addr  in  16  Z80 byte address.
- z_wdata  in  8  Z80 write data.
- z_wait  out  1  Z80 WAIT request, active-high.
- z_rdata  out  8  read data returned to the Z80; held until the next window cycle completes.
- z_done  out  1  one-cycle pulse when a cycle completes.
- bank  out  9  current bank register.
- m_br  out  1  68k bus request.
- m_bg  in  1  68k bus grant.
- m_bgack  out  1  bus-grant acknowledge.
- m_as  out  1  address strobe.
- m_uds  out  1  upper data strobe.
- m_lds  out  1  lower data strobe.
- m_rw  out  1  1 = read.
- m_addr  out  23  68k word address (A23:A1).
- m_wdata  out  16  68k write data.
- m_rdata  in  16  68k read data.
- m_dtack  in  1  68k data acknowledge, active-high.
- timeout  out  1  one-cycle pulse when a cycle is aborted for lack of DTACK.

Function
REQ-002 A bank write SHALL be a z_req with z_wr=1, z_addr[15:8]=0x60 and the FSM in IDLE.
- It SHALL update bank <= {z_wdata[0], bank[8:1]} at the next edge.
- It SHALL pulse z_done in the cycle after z_req.
- It SHALL leave z_wait at 0.
REQ-003 A window cycle SHALL be a z_req with z_addr[15]=1 and the FSM in IDLE.
REQ-004 The block SHALL ignore z_req for any other address: no outputs change.
REQ-005 The 68k byte address SHALL be {bank, z_addr[14:0]}, 24 bits; m_addr SHALL carry bits 23:1 of it.
REQ-006 Byte lane selection:
- Byte address bit0=0: the block SHALL use m_uds and return m_rdata[15:8].
- Byte address bit0=1: the block SHALL use m_lds and return m_rdata[7:0].
REQ-007 On writes, m_wdata SHALL be {z_wdata, z_wdata}.
REQ-008 On window-cycle acceptance the block SHALL latch address, z_wr and z_wdata; m_addr, m_wdata and m_rw SHALL hold those values until the FSM returns to IDLE.
REQ-009 The FSM SHALL have the states IDLE, REQ, OWN, CYC, REL, with outputs registered from the state as follows:
- IDLE: all bus outputs 0.
- Accepted window cycle: go to REQ; z_wait=1 and m_br=1 from the next cycle.
- REQ: hold m_br=1 until m_bg=1 is sampled, then go to OWN.
- OWN (exactly 1 cycle): m_bgack=1, m_br=0.
- CYC: m_bgack=1, m_as=1, selected strobe=1, m_rw=~wr; an 8-bit wait counter starts at 0 and increments each cycle.
- CYC, m_dtack=1 sampled: latch the selected read byte into z_rdata (reads only), then go to REL.
- CYC, counter=255 and m_dtack=0: pulse timeout, set z_rdata=0xFF on reads, then go to REL.
- REL (1 cycle): m_as and strobes 0, m_bgack=1.
- REL to IDLE: m_bgack=0, z_wait=0, z_done=1 for one cycle.
REQ-010 If m_dtack and the counter=255 condition coincide, DTACK SHALL win and timeout SHALL not pulse.
REQ-011 The block SHALL ignore z_req of any kind while the FSM is not in IDLE, including bank writes.
REQ-012 If m_bg drops while in REQ, the block SHALL keep waiting in REQ with m_br=1.
REQ-013 Latency with m_bg high in the cycle after REQ and DTACK on the first CYC cycle: z_req to z_done SHALL be 6 cycles.
REQ-014 The bank register SHALL wrap naturally as a 9-bit shift register; it has no overflow condition.

Reset
REQ-015 SRES=1 at an edge SHALL force the following by the next edge, including mid-cycle:
- FSM to IDLE and counter to 0.
- bank=0 and z_rdata=0x00.
- All outputs 0, including m_br, m_bgack, m_as, strobes, z_wait, z_done and timeout.
REQ-016 While SRES=1 the block SHALL ignore z_req.

Verification
REQ-017 Bank load: nine bank writes with data bit0 = 1,0,0,0,0,0,0,0,1 -> bank=0x101; z_done pulses 9 times; z_wait stays 0.
REQ-018 Read: bank=0x1FF, read at z_addr=0x8001; m_rdata=0xAB12 with DTACK on the first CYC cycle -> m_addr=0x7FC000, m_lds=1, m_uds=0, m_rw=1, z_rdata=0x12, z_done 6 cycles after z_req.
REQ-019 Write: bank=0, write 0x5A to z_addr=0x8000 -> m_uds=1, m_rw=0, m_wdata=0x5A5A, m_addr=0x000000.
REQ-020 Delayed grant and timeout:
- m_bg held low 20 cycles -> m_br stays 1 and m_bgack stays 0 throughout.
- No DTACK -> timeout pulses once after 256 CYC cycles; z_rdata=0xFF.
REQ-021 Reset mid-cycle: SRES pulsed in CYC -> next cycle m_as=0, m_bgack=0, z_wait=0, bank=0; a following z_req is processed normally.
REQ-022 Busy rejection: bank write and window z_req issued during CYC -> ignored; bank unchanged; exactly one z_done.

Source files
------------

// File: rtl/z80_bank_bridge.sv
// Bridges Z80 memory cycles into a banked window on a 68k bus: a 9-bit shift
// bank register plus an arbitrate/own/cycle/release sequence with DTACK timeout.
module z80_bank_bridge (
    input  logic        MCLK,
    input  logic        SRES,
    input  logic        z_req,
    input  logic        z_wr,
    input  logic [15:0] z_addr,
    input  logic [7:0]  z_wdata,
    output logic        z_wait,
    output logic [7:0]  z_rdata,
    output logic        z_done,
    output logic [8:0]  bank,
    output logic        m_br,
    input  logic        m_bg,
    output logic        m_bgack,
    output logic        m_as,
    output logic        m_uds,
    output logic        m_lds,
    output logic        m_rw,
    output logic [22:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_dtack,
    output logic        timeout
);

    localparam int unsigned BANK_W = 9;
    localparam int unsigned BYTE_ADDR_W = 24;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {IDLE, REQ, OWN, CYC, REL} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BANK_W-1:0]        bank_q, bank_d;
    logic [7:0]               rdata_q, rdata_d;
    logic [BYTE_ADDR_W-1:0]   baddr_q, baddr_d;
    logic                     wr_q, wr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic                     done_q, done_d;
    logic                     tmo_q, tmo_d;
    logic                     wait_q, wait_d;
    logic                     br_q, br_d;
    logic                     bgack_q, bgack_d;
    logic                     as_q, as_d;
    logic                     uds_q, uds_d;
    logic                     lds_q, lds_d;
    logic                     rw_q, rw_d;
    logic [22:0]              maddr_q, maddr_d;
    logic [15:0]              mwdata_q, mwdata_d;
    logic                     busy_d;

    // Next state, latched transaction fields and registered bus outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        rdata_d = rdata_q;
        baddr_d = baddr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (z_req) begin
                    if (z_addr[15]) begin
                        state_d = REQ;
                        baddr_d = {bank_q, z_addr[14:0]};
                        wr_d    = z_wr;
                        wdata_d = z_wdata;
                    end else if (z_wr && (z_addr[15:8] == 8'h60)) begin
                        bank_d = {z_wdata[0], bank_q[8:1]};
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (m_bg) state_d = OWN;
            end
            OWN: begin
                state_d = CYC;
                cnt_d   = '0;
            end
            CYC: begin
                cnt_d = cnt_q + CNT_W'(1);
                // DTACK takes priority over a timeout in the same cycle
                if (m_dtack) begin
                    if (!wr_q) rdata_d = baddr_q[0] ? m_rdata[7:0] : m_rdata[15:8];
                    state_d = REL;
                end else if (cnt_q == 8'hFF) begin
                    tmo_d = 1'b1;
                    if (!wr_q) rdata_d = 8'hFF;
                    state_d = REL;
                end
            end
            REL: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d != IDLE);
        wait_d   = busy_d;
        br_d     = (state_d == REQ);
        bgack_d  = (state_d == OWN) || (state_d == CYC) || (state_d == REL);
        as_d     = (state_d == CYC);
        uds_d    = (state_d == CYC) && !baddr_d[0];
        lds_d    = (state_d == CYC) && baddr_d[0];
        rw_d     = busy_d && !wr_d;
        maddr_d  = busy_d ? baddr_d[23:1] : 23'd0;
        mwdata_d = (busy_d && wr_d) ? {wdata_d, wdata_d} : 16'd0;
    end

    always_ff @(posedge MCLK) begin
        if (SRES) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bank_q   <= '0;
            rdata_q  <= '0;
            baddr_q  <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            wait_q   <= 1'b0;
            br_q     <= 1'b0;
            bgack_q  <= 1'b0;
            as_q     <= 1'b0;
            uds_q    <= 1'b0;
            lds_q    <= 1'b0;
            rw_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            rdata_q  <= rdata_d;
            baddr_q  <= baddr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            wait_q   <= wait_d;
            br_q     <= br_d;
            bgack_q  <= bgack_d;
            as_q     <= as_d;
            uds_q    <= uds_d;
            lds_q    <= lds_d;
            rw_q     <= rw_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    assign z_wait  = wait_q;
    assign z_rdata = rdata_q;
    assign z_done  = done_q;
    assign bank    = bank_q;
    assign m_br    = br_q;
    assign m_bgack = bgack_q;
    assign m_as    = as_q;
    assign m_uds   = uds_q;
    assign m_lds   = lds_q;
    assign m_rw    = rw_q;
    assign m_addr  = maddr_q;
    assign m_wdata = mwdata_q;
    assign timeout = tmo_q;

endmodule
